// File: rtl/writeback_regfile.sv
// Writeback stage plus 16x32 register file, with a forwarding port and retirement counters.
// Optional macro WB_REGFILE_BYPASS_EN: reads see the pending writeback in the same cycle.
module writeback_regfile (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        mem_valid,
    input  logic        mem_wr_en,
    input  logic [3:0]  mem_rd,
    input  logic [31:0] mem_val,
    input  logic [31:0] mem_pc,
    input  logic [3:0]  dprf_ra,
    input  logic [3:0]  dprf_rb,
    output logic [31:0] dprf_ra_val,
    output logic [31:0] dprf_rb_val,
    output logic [3:0]  fwd_b_addr,
    output logic [31:0] fwd_b_val,
    output logic [31:0] wb_retired_count,
    output logic [31:0] wb_last_pc
);

    logic [31:0] regs_q [16];
    logic [3:0]  wbRd_q, wbRd_d;
    logic [31:0] wbVal_q, wbVal_d;
    logic        wbWe_q, wbWe_d;
    logic [31:0] retiredCount_q, retiredCount_d;
    logic [31:0] lastPc_q, lastPc_d;

    // wbRd/wbVal hold when idle so the forward port always mirrors a committed value.
    always_comb begin
        wbWe_d         = mem_valid & mem_wr_en;
        wbRd_d         = wbRd_q;
        wbVal_d        = wbVal_q;
        retiredCount_d = retiredCount_q;
        lastPc_d       = lastPc_q;
        if (wbWe_d) begin
            wbRd_d  = mem_rd;
            wbVal_d = mem_val;
        end
        if (mem_valid) begin
            retiredCount_d = retiredCount_q + 32'd1;
            lastPc_d       = mem_pc;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= 32'd0;
            end
            wbRd_q         <= 4'd0;
            wbVal_q        <= 32'd0;
            wbWe_q         <= 1'b0;
            retiredCount_q <= 32'd0;
            lastPc_q       <= 32'd0;
        end else begin
            if (wbWe_q) begin
                regs_q[wbRd_q] <= wbVal_q;
            end
            wbRd_q         <= wbRd_d;
            wbVal_q        <= wbVal_d;
            wbWe_q         <= wbWe_d;
            retiredCount_q <= retiredCount_d;
            lastPc_q       <= lastPc_d;
        end
    end

    always_comb begin
        dprf_ra_val = regs_q[dprf_ra];
        dprf_rb_val = regs_q[dprf_rb];
`ifdef WB_REGFILE_BYPASS_EN
        if (wbWe_q && (dprf_ra == wbRd_q)) begin
            dprf_ra_val = wbVal_q;
        end
        if (wbWe_q && (dprf_rb == wbRd_q)) begin
            dprf_rb_val = wbVal_q;
        end
`endif
    end

    assign fwd_b_addr       = wbRd_q;
    assign fwd_b_val        = wbVal_q;
    assign wb_retired_count = retiredCount_q;
    assign wb_last_pc       = lastPc_q;

endmodule
